// File: rtl/rf_ctx_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_ctx_sequencer_pkg
// Brief   : Shared constants, state encoding and checksum helper for the
//           register-file context sequencer (RF_CTX_CHECKSUM_EN adds a 9th word).
// Revision: 1.0 - initial release
// ============================================================================
package rf_ctx_sequencer_pkg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int SEL_W    = 3;

`ifdef RF_CTX_CHECKSUM_EN
  // Extra index bit lets the counter reach the trailing checksum word.
  localparam int IDX_W     = SEL_W + 1;
  localparam int NUM_WORDS = NUM_REGS + 1;
`else
  localparam int IDX_W     = SEL_W;
  localparam int NUM_WORDS = NUM_REGS;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SAVE    = 2'b01,
    RESTORE = 2'b10,
    DONE    = 2'b11
  } ctx_state_e;

  function automatic logic [DATA_W-1:0] foldWord(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_ctx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : rf_ctx_sequencer_if
// Brief   : Save (out) and restore (in) valid/ready context streams.
// Revision: 1.0 - initial release
// ============================================================================
interface rf_ctx_sequencer_if
  import rf_ctx_sequencer_pkg::*;
();

  logic [DATA_W-1:0] ctx_out_data;
  logic              ctx_out_valid;
  logic              ctx_out_ready;
  logic [DATA_W-1:0] ctx_in_data;
  logic              ctx_in_valid;
  logic              ctx_in_ready;

  // master = sequencer, slave = debug/context-switch unit
  modport master (
    output ctx_out_data, ctx_out_valid, ctx_in_ready,
    input  ctx_out_ready, ctx_in_data, ctx_in_valid
  );

  modport slave (
    input  ctx_out_data, ctx_out_valid, ctx_in_ready,
    output ctx_out_ready, ctx_in_data, ctx_in_valid
  );

endinterface
`default_nettype wire

// File: rtl/rf_ctx_sequencer_rf_port_mux.sv
`default_nettype none
// ============================================================================
// Module  : rf_port_mux
// Brief   : Selects pipeline or sequencer ownership of RF read-1 and write ports.
// Revision: 1.0 - initial release
// ============================================================================
module rf_port_mux
  import rf_ctx_sequencer_pkg::*;
(
  input  ctx_state_e        state,
  input  logic [SEL_W-1:0]  seqSel,
  input  logic [DATA_W-1:0] seqWriteData,
  input  logic              seqWriteEn,
  input  logic [SEL_W-1:0]  pipe_read1RegSel,
  input  logic [SEL_W-1:0]  pipe_writeRegSel,
  input  logic [DATA_W-1:0] pipe_writeData,
  input  logic              pipe_writeEn,
  output logic [SEL_W-1:0]  rf_read1RegSel,
  output logic [SEL_W-1:0]  rf_writeRegSel,
  output logic [DATA_W-1:0] rf_writeData,
  output logic              rf_writeEn
);

  always_comb begin
    rf_read1RegSel = pipe_read1RegSel;
    rf_writeRegSel = pipe_writeRegSel;
    rf_writeData   = pipe_writeData;
    rf_writeEn     = 1'b0;
    case (state)
      IDLE: begin
        rf_writeEn = pipe_writeEn;
      end
      SAVE: begin
        rf_read1RegSel = seqSel;
      end
      RESTORE: begin
        rf_writeRegSel = seqSel;
        rf_writeData   = seqWriteData;
        rf_writeEn     = seqWriteEn;
      end
      default: begin
        rf_writeEn = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rf_ctx_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rf_ctx_sequencer
// Brief   : Register-file controller streaming R0..R7 out (save) or in (restore),
//           stalling the pipeline meanwhile. Option: RF_CTX_CHECKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
module rf_ctx_sequencer
  import rf_ctx_sequencer_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          save_req,
  input  wire logic          restore_req,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               pipe_stall,
  input  wire logic [SEL_W-1:0]  pipe_read1RegSel,
  input  wire logic [SEL_W-1:0]  pipe_writeRegSel,
  input  wire logic [DATA_W-1:0] pipe_writeData,
  input  wire logic              pipe_writeEn,
  output logic [SEL_W-1:0]   rf_read1RegSel,
  input  wire logic [DATA_W-1:0] rf_read1Data,
  output logic [SEL_W-1:0]   rf_writeRegSel,
  output logic [DATA_W-1:0]  rf_writeData,
  output logic               rf_writeEn,
  rf_ctx_sequencer_if.master ctx
);

  localparam logic [IDX_W-1:0] c_lastIdx = IDX_W'(NUM_WORDS - 1);

  ctx_state_e       r_state;
  ctx_state_e       w_stateNext;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idxNext;
  logic             w_xfer;
  logic             w_regWord;
  logic             w_csumErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (save_req) begin
          w_stateNext = SAVE;
          w_idxNext   = '0;
        end else if (restore_req) begin
          w_stateNext = RESTORE;
          w_idxNext   = '0;
        end
      end
      SAVE:    w_xfer = ctx.ctx_out_ready;
      RESTORE: w_xfer = ctx.ctx_in_valid;
      default: w_stateNext = IDLE;
    endcase
    if (w_xfer) begin
      if (r_idx == c_lastIdx) begin
        w_stateNext = DONE;
      end else begin
        w_idxNext = r_idx + IDX_W'(1);
      end
    end
  end

  assign busy              = (r_state != IDLE);
  assign pipe_stall        = busy;
  assign done              = (r_state == DONE);
  assign ctx.ctx_out_valid = (r_state == SAVE);
  assign ctx.ctx_in_ready  = (r_state == RESTORE);
  assign err               = (busy && pipe_writeEn) || w_csumErr;

`ifdef RF_CTX_CHECKSUM_EN
  logic [DATA_W-1:0] r_acc;
  logic              r_csumBad;
  logic [DATA_W-1:0] w_xferWord;

  // Top index bit marks the trailing checksum word, which never touches the RF.
  assign w_regWord  = !r_idx[IDX_W-1];
  assign w_xferWord = (r_state == SAVE) ? rf_read1Data : ctx.ctx_in_data;
  assign ctx.ctx_out_data = w_regWord ? rf_read1Data : r_acc;
  assign w_csumErr  = done && r_csumBad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_csumBad <= 1'b0;
    end else if ((r_state == IDLE) && (save_req || restore_req)) begin
      r_acc     <= '0;
      r_csumBad <= 1'b0;
    end else if (w_xfer && w_regWord) begin
      r_acc <= foldWord(r_acc, w_xferWord);
    end else if (w_xfer && (r_state == RESTORE)) begin
      r_csumBad <= (ctx.ctx_in_data != r_acc);
    end
  end
`else
  assign w_regWord        = 1'b1;
  assign ctx.ctx_out_data = rf_read1Data;
  assign w_csumErr        = 1'b0;
`endif

  rf_port_mux u_portMux (
    .state            (r_state),
    .seqSel           (r_idx[SEL_W-1:0]),
    .seqWriteData     (ctx.ctx_in_data),
    .seqWriteEn       (ctx.ctx_in_valid && w_regWord),
    .pipe_read1RegSel (pipe_read1RegSel),
    .pipe_writeRegSel (pipe_writeRegSel),
    .pipe_writeData   (pipe_writeData),
    .pipe_writeEn     (pipe_writeEn),
    .rf_read1RegSel   (rf_read1RegSel),
    .rf_writeRegSel   (rf_writeRegSel),
    .rf_writeData     (rf_writeData),
    .rf_writeEn       (rf_writeEn)
  );

endmodule
`default_nettype wire
